// File: rtl/interrupt_sequencer.sv
// Reset / NMI / IRQ entry sequencer for a 6502-style core: picks the interrupt source,
// forces the BRK opcode and walks the 7-cycle push/vector-fetch sequence.
module interrupt_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       res_n,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       flag_i,
    input  logic       sync,
    output logic       force_brk,
    output logic       int_active,
    output logic [7:0] sig_interrupt,
    output logic       suppress_write,
    output logic       set_i,
    output logic       b_flag,
    output logic [2:0] seq_cycle
);

    typedef enum logic [1:0] {ST_RESET, ST_IDLE, ST_SEQ} state_t;
    typedef enum logic [1:0] {K_RES, K_NMI, K_IRQ} kind_t;

    state_t     state, state_nxt;
    kind_t      kind, kind_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       nmi_q;
    logic       nmi_pending, pend_nxt, pend_clr;
    logic       nmi_edge, irq_req;

    assign nmi_edge = nmi_q & ~nmi_n;
    assign irq_req  = ~irq_n & ~flag_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RESET;
            kind        <= K_RES;
            cnt         <= '0;
            nmi_q       <= 1'b1;
            nmi_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            kind        <= kind_nxt;
            cnt         <= cnt_nxt;
            nmi_q       <= nmi_n;
            nmi_pending <= pend_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        cnt_nxt   = cnt;
        pend_clr  = 1'b0;
        case (state)
            ST_RESET: begin
                if (res_n) begin
                    state_nxt = ST_SEQ;
                    kind_nxt  = K_RES;
                    cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (sync && rdy && (nmi_pending || irq_req)) begin
                    state_nxt = ST_SEQ;
                    cnt_nxt   = '0;
                    kind_nxt  = nmi_pending ? K_NMI : K_IRQ;
                    pend_clr  = nmi_pending;
                end
            end
            ST_SEQ: begin
                if (rdy) begin
                    if (cnt == 3'd6) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 3'd1;
                    end
                end
                // NMI can still take over an IRQ until the vector fetch begins
                if (kind == K_IRQ && nmi_pending && cnt <= 3'd3) begin
                    kind_nxt = K_NMI;
                    pend_clr = 1'b1;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
        if (!res_n) begin
            state_nxt = ST_RESET;
            kind_nxt  = K_RES;
            cnt_nxt   = '0;
            pend_clr  = 1'b0;
        end
        pend_nxt = (nmi_pending & ~pend_clr) | nmi_edge;
    end

    always_comb begin
        force_brk      = 1'b0;
        int_active     = 1'b0;
        sig_interrupt  = '0;
        suppress_write = 1'b0;
        set_i          = 1'b0;
        b_flag         = 1'b0;
        seq_cycle      = '0;
        case (state)
            ST_RESET: begin
                int_active     = 1'b1;
                suppress_write = 1'b1;
            end
            ST_SEQ: begin
                int_active     = 1'b1;
                force_brk      = (cnt == 3'd0);
                set_i          = (cnt == 3'd6);
                suppress_write = (kind == K_RES);
                seq_cycle      = cnt;
                if (cnt == 3'd5 || cnt == 3'd6) begin
                    case (kind)
                        K_RES:   sig_interrupt = 8'hFC;
                        K_NMI:   sig_interrupt = 8'hFA;
                        default: sig_interrupt = 8'hFE;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Table-driven, scoreboarded bench for interrupt_sequencer; each row is one clock of
// stimulus plus the outputs expected after that edge.
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rdy, res_n, nmi_n, irq_n, flag_i, sync;
    logic       force_brk, int_active, suppress_write, set_i, b_flag;
    logic [7:0] sig_interrupt;
    logic [2:0] seq_cycle;
    logic [15:0] outs;

    int checks   = 0;
    int failures = 0;

    interrupt_sequencer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .res_n(res_n), .nmi_n(nmi_n),
        .irq_n(irq_n), .flag_i(flag_i), .sync(sync),
        .force_brk(force_brk), .int_active(int_active), .sig_interrupt(sig_interrupt),
        .suppress_write(suppress_write), .set_i(set_i), .b_flag(b_flag),
        .seq_cycle(seq_cycle)
    );

    always #5 clk = ~clk;

    assign outs = {int_active, force_brk, sig_interrupt, suppress_write, set_i, b_flag, seq_cycle};

    // stim = {rdy, res_n, nmi_n, irq_n, flag_i, sync}
    typedef struct {
        string       name;
        logic [5:0]  stim;
        logic [15:0] exp;
    } vec_t;

    localparam logic [5:0] QUIET      = 6'b111110;
    localparam logic [5:0] IRQ_SYNC   = 6'b111001;
    localparam logic [5:0] IRQ_MASKED = 6'b111011;
    localparam logic [5:0] NMI_LOW    = 6'b110110;
    localparam logic [5:0] NMI_LOW_S  = 6'b110111;
    localparam logic [5:0] SYNC_ONLY  = 6'b111111;
    localparam logic [5:0] RDY0       = 6'b011110;
    localparam logic [5:0] RDY0_IRQ   = 6'b011001;
    localparam logic [5:0] RES_LOW    = 6'b101110;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic logic [15:0] o(logic ia, logic fb, logic [7:0] sig, logic sw,
                                      logic si, logic [2:0] sc);
        return {ia, fb, sig, sw, si, 1'b0, sc};
    endfunction

    localparam logic [15:0] E_IDLE = 16'h0000;
    localparam logic [15:0] E_RST  = {1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0};

    function automatic logic [15:0] seqo(int c, logic [7:0] v, logic sw);
        logic [2:0] c3;
        c3 = c[2:0];
        return o(1'b1, c == 0, (c >= 5) ? v : 8'h00, sw, c == 6, c3);
    endfunction

    function automatic vec_t mk(string nm, logic [5:0] stim, logic [15:0] exp);
        vec_t v;
        v.name = nm;
        v.stim = stim;
        v.exp  = exp;
        return v;
    endfunction

    task automatic add(string nm, logic [5:0] stim, logic [15:0] exp);
        tbl.push_back(mk(nm, stim, exp));
    endtask

    task automatic add_run(string nm, logic [5:0] stim, int first, int last,
                           logic [7:0] v, logic sw);
        for (int c = first; c <= last; c++)
            tbl.push_back(mk($sformatf("%s_c%0d", nm, c), stim, seqo(c, v, sw)));
    endtask

    task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %04h expected %04h (ia,fb,sig,sw,si,b,cyc)", nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        vec_t e;
        {rdy, res_n, nmi_n, irq_n, flag_i, sync} = v.stim;
        exp_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check(e.name, outs, e.exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {rdy, res_n, nmi_n, irq_n, flag_i, sync} = QUIET;

        // Reset release -> RES sequence
        add("res_c0", QUIET, seqo(0, 8'hFC, 1'b1));
        add_run("res", QUIET, 1, 6, 8'hFC, 1'b1);
        add("res_done", QUIET, E_IDLE);
        // IRQ sequence with sync held high throughout (ignored in SEQ)
        add("irq_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0));
        add_run("irq", IRQ_SYNC, 1, 6, 8'hFE, 1'b0);
        add("irq_done", QUIET, E_IDLE);
        add("irq_masked1", IRQ_MASKED, E_IDLE);
        add("irq_masked2", IRQ_MASKED, E_IDLE);
        // One-cycle NMI pulse, serviced at a later sync
        add("nmi_fall", NMI_LOW, E_IDLE);
        add("nmi_rise", QUIET, E_IDLE);
        add("nmi_accept", SYNC_ONLY, seqo(0, 8'hFA, 1'b0));
        add_run("nmi", QUIET, 1, 6, 8'hFA, 1'b0);
        add("nmi_done", QUIET, E_IDLE);
        // NMI held low: exactly one sequence
        add("hold_fall", NMI_LOW, E_IDLE);
        add("hold_accept", NMI_LOW_S, seqo(0, 8'hFA, 1'b0));
        add_run("hold", NMI_LOW, 1, 6, 8'hFA, 1'b0);
        add("hold_done", NMI_LOW_S, E_IDLE);
        add("hold_none1", NMI_LOW_S, E_IDLE);
        add("hold_none2", NMI_LOW_S, E_IDLE);
        add("hold_release", QUIET, E_IDLE);
        // NMI edge at cnt=2 hijacks the IRQ
        add("hj_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0));
        add_run("hj", QUIET, 1, 2, 8'hFE, 1'b0);
        add("hj_fall", NMI_LOW, seqo(3, 8'hFA, 1'b0));
        add("hj_rise", QUIET, seqo(4, 8'hFA, 1'b0));
        add_run("hj", QUIET, 5, 6, 8'hFA, 1'b0);
        add("hj_done", QUIET, E_IDLE);
        add("hj_no_pending", SYNC_ONLY, E_IDLE);
        // NMI edge at cnt=3: pending only from cnt=4, no hijack
        add("b4_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0));
        add_run("b4", QUIET, 1, 3, 8'hFE, 1'b0);
        add("b4_fall", NMI_LOW, seqo(4, 8'hFE, 1'b0));
        add_run("b4", QUIET, 5, 6, 8'hFE, 1'b0);
        add("b4_end", QUIET, E_IDLE);
        add("b4_service", SYNC_ONLY, seqo(0, 8'hFA, 1'b0));
        add_run("b4_nmi", QUIET, 1, 6, 8'hFA, 1'b0);
        add("b4_done", QUIET, E_IDLE);
        // NMI edge at cnt=5: IRQ vector kept, NMI serviced next sync
        add("late_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0));
        add_run("late", QUIET, 1, 5, 8'hFE, 1'b0);
        add("late_fall", NMI_LOW, seqo(6, 8'hFE, 1'b0));
        add("late_end", QUIET, E_IDLE);
        add("late_service", SYNC_ONLY, seqo(0, 8'hFA, 1'b0));
        add_run("late_nmi", QUIET, 1, 6, 8'hFA, 1'b0);
        add("late_done", QUIET, E_IDLE);

        #1 rst = 1'b1;
        #1 check("reset_state", outs, E_RST);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // rdy low: no acceptance, then counter frozen at cnt=4 for 3 cycles
        apply(mk("rdy0_no_accept", RDY0_IRQ, E_IDLE));
        apply(mk("stall_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0)));
        for (int c = 1; c <= 4; c++)
            apply(mk($sformatf("stall_c%0d", c), QUIET, seqo(c, 8'hFE, 1'b0)));
        for (int k = 0; k < 3; k++)
            apply(mk($sformatf("stall_hold%0d", k), RDY0, seqo(4, 8'hFE, 1'b0)));
        for (int c = 5; c <= 6; c++)
            apply(mk($sformatf("stall_c%0d", c), QUIET, seqo(c, 8'hFE, 1'b0)));
        apply(mk("stall_done", QUIET, E_IDLE));

        // res_n low at cnt=3 aborts into RESET, RES sequence after release
        apply(mk("ab_accept", IRQ_SYNC, seqo(0, 8'hFE, 1'b0)));
        for (int c = 1; c <= 3; c++)
            apply(mk($sformatf("ab_c%0d", c), QUIET, seqo(c, 8'hFE, 1'b0)));
        apply(mk("ab_res0", RES_LOW, E_RST));
        apply(mk("ab_res0_hold", RES_LOW, E_RST));
        apply(mk("ab_res1", QUIET, seqo(0, 8'hFC, 1'b1)));
        for (int c = 1; c <= 6; c++)
            apply(mk($sformatf("ab_res_c%0d", c), QUIET, seqo(c, 8'hFC, 1'b1)));
        apply(mk("ab_done", QUIET, E_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high block reset.
REQ-003 SHALL have port rdy, input, 1 bit: CPU RDY; 0 freezes the sequence counter and acceptance.
REQ-004 SHALL have port res_n, input, 1 bit: CPU RES pin, active-low, level-sensitive.
REQ-005 SHALL have port nmi_n, input, 1 bit: NMI pin, active-low, falling-edge-sensitive.
REQ-006 SHALL have port irq_n, input, 1 bit: IRQ pin, active-low, level-sensitive.
REQ-007 SHALL have port flag_i, input, 1 bit: P register I flag; 1 masks IRQ.
REQ-008 SHALL have port sync, input, 1 bit: opcode-fetch (T1) cycle indicator from timing logic.
REQ-009 SHALL have port force_brk, output, 1 bit: substitute opcode 0x00 into IR.
REQ-010 SHALL have port int_active, output, 1 bit: reset hold or interrupt sequence in progress.
REQ-011 SHALL have port sig_interrupt, output, 8 bits: vector low byte for ADL during vector fetch.
REQ-012 SHALL have port suppress_write, output, 1 bit: force R/W to read (reset sequence pushes).
REQ-013 SHALL have port set_i, output, 1 bit: set I flag this cycle.
REQ-014 SHALL have port b_flag, output, 1 bit: B bit value for the pushed P.
REQ-015 SHALL have port seq_cycle, output, 3 bits: current sequence cycle 0..6.

Function
REQ-016 SHALL implement states RESET, IDLE, SEQ; source kind register in {RES, NMI, IRQ}; 3-bit counter cnt.
REQ-017 SHALL register nmi_n every clk irrespective of rdy; a falling edge (previous 1, current 0) SHALL set nmi_pending.
REQ-018 SHALL give priority RES > NMI > IRQ; IRQ is never latched, only sampled as irq_n==0 and flag_i==0.
REQ-019 SHALL enter RESET from any state whenever res_n==0 at a clk edge, aborting any sequence; nmi_pending kept.
REQ-020 SHALL, in RESET with res_n==1 at a clk edge, enter SEQ with kind=RES, cnt=0.
REQ-021 SHALL, in IDLE at an edge with sync=1, rdy=1 and (nmi_pending or IRQ condition), enter SEQ with cnt=0 and kind=NMI if nmi_pending else IRQ; NMI acceptance clears nmi_pending in the same edge.
REQ-022 SHALL, in SEQ, increment cnt on each edge with rdy=1, hold when rdy=0, and at cnt==6 with rdy=1 return to IDLE.
REQ-023 SHALL, with kind=IRQ, cnt<=3 and nmi_pending=1, change kind to NMI at the next edge and clear nmi_pending (NMI hijack); no hijack at cnt>=4.
REQ-024 SHALL drive force_brk=1 only in SEQ with cnt==0.
REQ-025 SHALL drive sig_interrupt in SEQ with cnt in {5,6}: 0xFC RES, 0xFA NMI, 0xFE IRQ; otherwise 0x00.
REQ-026 SHALL drive suppress_write=1 in RESET and in SEQ with kind=RES; else 0.
REQ-027 SHALL drive set_i=1 in SEQ with cnt==6; b_flag=0 always (software BRK B=1 handled elsewhere).
REQ-028 SHALL drive int_active=1 in RESET or SEQ; seq_cycle=cnt in SEQ, 0 otherwise.
REQ-029 SHALL derive all outputs from registered state only (no combinational input-to-output path).
REQ-030 SHALL ignore sync while in SEQ or RESET; a new NMI edge during SEQ sets nmi_pending for later service.

Reset
REQ-031 SHALL on rst=1 asynchronously set state=RESET, cnt=0, kind=RES, nmi_pending=0, nmi sample register=1.
REQ-032 SHALL therefore present after rst: int_active=1, suppress_write=1, force_brk=0, sig_interrupt=0x00, set_i=0, seq_cycle=0.

Verification
REQ-033 rst, res_n=1, rdy=1 -> SEQ kind RES; force_brk at cycle 0, sig_interrupt=0xFC at cycles 5-6, suppress_write=1 throughout, set_i at cycle 6, then IDLE.
REQ-034 irq_n=0, flag_i=0, sync pulse -> 7-cycle sequence, sig_interrupt=0xFE at cycles 5-6; repeat with flag_i=1 -> no sequence.
REQ-035 nmi_n 1->0 pulse of one cycle while sync=0, later sync -> NMI sequence, 0xFA; nmi_n held low -> no second sequence.
REQ-036 IRQ sequence, NMI edge at cnt=2 -> vector 0xFA, nmi_pending cleared; NMI edge at cnt=5 -> vector 0xFE, NMI serviced at next sync.
REQ-037 rdy=0 for 3 cycles at cnt=4 -> cnt holds at 4, sequence ends 3 cycles late; res_n=0 at cnt=3 -> RESET immediately, RES sequence after release.
